// File: rtl/cdb_arbiter_if.sv
// Writeback request/broadcast bundle between functional units and the CDB arbiter.
// Functional units (or a bench) use the master modport; the arbiter uses the slave modport.
interface cdb_arbiter_if #(
  parameter int N_REQ         = 4,
  parameter int ROB_IDX_WIDTH = 5
);
  logic [N_REQ-1:0]                    req_valid;
  logic [N_REQ-1:0][ROB_IDX_WIDTH-1:0] req_rob_idx;
  logic [N_REQ-1:0][4:0]               req_rd_addr;
  logic [N_REQ-1:0][31:0]              req_data;
  logic [N_REQ-1:0]                    req_ready;

  logic                                cdb_valid;
  logic [ROB_IDX_WIDTH-1:0]            cdb_rob_idx;
  logic [4:0]                          cdb_rd_addr;
  logic [31:0]                         cdb_data;

  modport master (
    output req_valid, req_rob_idx, req_rd_addr, req_data,
    input  req_ready, cdb_valid, cdb_rob_idx, cdb_rd_addr, cdb_data
  );

  modport slave (
    input  req_valid, req_rob_idx, req_rd_addr, req_data,
    output req_ready, cdb_valid, cdb_rob_idx, cdb_rd_addr, cdb_data
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Common data bus writeback arbiter: one-hot combinational grant, registered broadcast one cycle later.
// Define CDB_RR_EN for round-robin arbitration; otherwise fixed priority with requester 0 highest.
module cdb_arbiter #(
  parameter int N_REQ         = 4,
  parameter int ROB_IDX_WIDTH = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  cdb_arbiter_if.slave bus
);

  localparam int               PTR_W   = $clog2(N_REQ);
  localparam logic [PTR_W:0]   N_REQ_L = (PTR_W+1)'(N_REQ);
  localparam logic [PTR_W-1:0] LAST_IX = PTR_W'(N_REQ - 1);

  logic                     grant_any;
  logic [PTR_W-1:0]         grant_idx;
  logic [N_REQ-1:0]         grant_vec;
  logic [PTR_W-1:0]         scan_base;
  logic [PTR_W:0]           scan_idx;

  logic                     cdb_valid_q,   cdb_valid_d;
  logic [ROB_IDX_WIDTH-1:0] cdb_rob_idx_q, cdb_rob_idx_d;
  logic [4:0]               cdb_rd_addr_q, cdb_rd_addr_d;
  logic [31:0]              cdb_data_q,    cdb_data_d;

`ifdef CDB_RR_EN
  logic [PTR_W-1:0]         rr_ptr_q, rr_ptr_d;

  assign scan_base = rr_ptr_q;
`else
  assign scan_base = '0;
`endif

  // The scan only looks at req_valid and the pointer so no payload bit reaches req_ready.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path leaves one
    // unassigned and no latch is inferred; blocking '=' is right inside always_comb.
    grant_any = 1'b0;
    grant_idx = '0;
    grant_vec = '0;
    scan_idx  = '0;
    if (!rst && !flush) begin
      for (int i = 0; i < N_REQ; i++) begin
        scan_idx = {1'b0, scan_base} + (PTR_W+1)'(i);
        if (scan_idx >= N_REQ_L) scan_idx = scan_idx - N_REQ_L;
        if (!grant_any && bus.req_valid[scan_idx[PTR_W-1:0]]) begin
          grant_any = 1'b1;
          grant_idx = scan_idx[PTR_W-1:0];
        end
      end
    end
    if (grant_any) grant_vec[grant_idx] = 1'b1;
  end

  always_comb begin
    cdb_valid_d   = grant_any;
    cdb_rob_idx_d = cdb_rob_idx_q;
    cdb_rd_addr_d = cdb_rd_addr_q;
    cdb_data_d    = cdb_data_q;
    if (grant_any) begin
      cdb_rob_idx_d = bus.req_rob_idx[grant_idx];
      cdb_rd_addr_d = bus.req_rd_addr[grant_idx];
      cdb_data_d    = bus.req_data[grant_idx];
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking '<=' so every flop samples pre-edge values.
    if (rst) begin
      cdb_valid_q   <= 1'b0;
      cdb_rob_idx_q <= '0;
      cdb_rd_addr_q <= '0;
      cdb_data_q    <= '0;
    end else begin
      cdb_valid_q   <= cdb_valid_d;
      cdb_rob_idx_q <= cdb_rob_idx_d;
      cdb_rd_addr_q <= cdb_rd_addr_d;
      cdb_data_q    <= cdb_data_d;
    end
  end

`ifdef CDB_RR_EN
  // Pointer moves just past the winner; flush and idle cycles leave it alone.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_any) rr_ptr_d = (grant_idx == LAST_IX) ? '0 : grant_idx + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) rr_ptr_q <= '0;
    else     rr_ptr_q <= rr_ptr_d;
  end
`else
  logic unused_last_ix;
  assign unused_last_ix = ^LAST_IX;
`endif

  assign bus.req_ready   = grant_vec;
  assign bus.cdb_valid   = cdb_valid_q;
  assign bus.cdb_rob_idx = cdb_rob_idx_q;
  assign bus.cdb_rd_addr = cdb_rd_addr_q;
  assign bus.cdb_data    = cdb_data_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: grant model plus a queue of expected CDB broadcasts.
// Expected grant order follows CDB_RR_EN the same way the design does.
module tb_cdb_arbiter;

  localparam int N_REQ         = 4;
  localparam int ROB_IDX_WIDTH = 5;

  typedef struct packed {
    logic                     v;
    logic [ROB_IDX_WIDTH-1:0] rob;
    logic [4:0]               rd;
    logic [31:0]              data;
  } cdb_t;

  logic clk = 1'b0;
  logic rst;
  logic flush;

  logic [N_REQ-1:0]                    tb_valid;
  logic [N_REQ-1:0][ROB_IDX_WIDTH-1:0] tb_rob;
  logic [N_REQ-1:0][4:0]               tb_rd;
  logic [N_REQ-1:0][31:0]              tb_data;

  int   n_cmp = 0;
  int   n_err = 0;
  int   model_ptr = 0;
  cdb_t model_cdb = '0;
  cdb_t exp_q[$];
  bit   drop_on_grant = 1'b0;

  always #5 clk = ~clk;

  cdb_arbiter_if #(.N_REQ(N_REQ), .ROB_IDX_WIDTH(ROB_IDX_WIDTH)) bus ();

  assign bus.req_valid   = tb_valid;
  assign bus.req_rob_idx = tb_rob;
  assign bus.req_rd_addr = tb_rd;
  assign bus.req_data    = tb_data;

  cdb_arbiter #(.N_REQ(N_REQ), .ROB_IDX_WIDTH(ROB_IDX_WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int model_pick();
    if (rst || flush) return -1;
`ifdef CDB_RR_EN
    for (int i = 0; i < N_REQ; i++)
      if (tb_valid[(model_ptr + i) % N_REQ]) return (model_ptr + i) % N_REQ;
`else
    for (int i = 0; i < N_REQ; i++)
      if (tb_valid[i]) return i;
`endif
    return -1;
  endfunction

  task automatic new_payload(input int i);
    tb_rob[i]  = ROB_IDX_WIDTH'($urandom);
    tb_rd[i]   = 5'($urandom);
    tb_data[i] = $urandom;
  endtask

  task automatic set_req(input int i, input logic [4:0] rob, input logic [4:0] rd, input logic [31:0] data);
    tb_valid[i] = 1'b1;
    tb_rob[i]   = rob;
    tb_rd[i]    = rd;
    tb_data[i]  = data;
  endtask

  // One clock: check grant and the broadcast due now, queue the next broadcast, then retire the winner.
  task automatic cycle();
    int               k;
    logic [N_REQ-1:0] exp_ready;
    cdb_t             e;
    @(negedge clk);
    k = model_pick();
    exp_ready = '0;
    if (k >= 0) exp_ready[k] = 1'b1;
    check("req_ready", 64'(bus.req_ready), 64'(exp_ready));
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("cdb_valid",   64'(bus.cdb_valid),   64'(e.v));
      check("cdb_rob_idx", 64'(bus.cdb_rob_idx), 64'(e.rob));
      check("cdb_rd_addr", 64'(bus.cdb_rd_addr), 64'(e.rd));
      check("cdb_data",    64'(bus.cdb_data),    64'(e.data));
    end
    if (rst) begin
      model_cdb = '0;
      model_ptr = 0;
    end else if (k >= 0) begin
      model_cdb = '{v: 1'b1, rob: tb_rob[k], rd: tb_rd[k], data: tb_data[k]};
`ifdef CDB_RR_EN
      model_ptr = (k + 1) % N_REQ;
`endif
    end else begin
      model_cdb.v = 1'b0;
    end
    exp_q.push_back(model_cdb);
    @(posedge clk);
    #1;
    if (k >= 0) begin
      if (drop_on_grant) tb_valid[k] = 1'b0;
      new_payload(k);
    end
  endtask

  initial begin
    rst      = 1'b1;
    flush    = 1'b0;
    tb_valid = '1;
    for (int i = 0; i < N_REQ; i++) new_payload(i);

    // Reset held with everyone valid: no grant, CDB idle and zeroed.
    cycle();
    cycle();
    rst = 1'b0;

    // Continuous all-valid load; first grant after reset goes to 0.
    drop_on_grant = 1'b0;
    for (int c = 0; c < 8; c++) cycle();

    // Single requester 2.
    tb_valid      = '0;
    drop_on_grant = 1'b1;
    cycle();
    set_req(2, 5'd7, 5'd5, 32'hDEAD_BEEF);
    cycle();
    cycle();
    cycle();

    // Only 1 and 3 valid: skip and wrap, then all valid to expose the pointer.
    set_req(1, 5'd1, 5'd11, 32'h1111_0001);
    set_req(3, 5'd3, 5'd13, 32'h3333_0003);
    cycle();
    cycle();
    tb_valid = '1;
    cycle();
    cycle();
    cycle();
    cycle();
    tb_valid = '0;
    cycle();

    // Flush right after a grant to requester 0.
    set_req(0, 5'd20, 5'd2, 32'hA5A5_0000);
    cycle();
    flush = 1'b1;
    set_req(1, 5'd21, 5'd3, 32'h5A5A_1111);
    cycle();
    flush = 1'b0;
    cycle();
    cycle();

    // Destination x0 is still broadcast.
    set_req(1, 5'd12, 5'd0, 32'h0000_CAFE);
    cycle();
    cycle();

    // Reset takes priority over an active transfer.
    drop_on_grant = 1'b0;
    tb_valid      = '1;
    cycle();
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    cycle();
    cycle();

    // Random traffic with occasional flush; requesters hold until granted.
    drop_on_grant = 1'b1;
    tb_valid      = '0;
    for (int c = 0; c < 60; c++) begin
      for (int i = 0; i < N_REQ; i++)
        if (!tb_valid[i] && ($urandom_range(2) == 0)) begin
          tb_valid[i] = 1'b1;
          new_payload(i);
        end
      flush = ($urandom_range(7) == 0);
      cycle();
    end
    flush    = 1'b0;
    tb_valid = '0;
    cycle();
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Writeback arbiter between the out-of-order core's functional units and the single common data bus (CDB). Each cycle it selects at most one completed result from up to `N_REQ` requesters and broadcasts it one cycle later to the register alias table/architectural register file, the ROB and the reservation stations. It owns the only path onto the CDB, so no other block drives `cdb_*`.

## Interface
- `N_REQ`, 4, number of requesting functional units (requester 0 = ALU, 1 = MUL/DIV, 2 = LSU, 3 = branch unit); legal range 2..8.
- `ROB_IDX_WIDTH`, 5, width of a ROB index tag.
- Clocking: one clock; reset is synchronous and active-high.
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  mispredict/exception flush from the ROB.
- `req_valid`  in  `N_REQ`  requester i holds a completed result.
- `req_rob_idx`  in  `N_REQ` x `ROB_IDX_WIDTH`  ROB tag of each result.
- `req_rd_addr`  in  `N_REQ` x 5  destination architectural register; 0 means no register write.
- `req_data`  in  `N_REQ` x 32  result value.
- `req_ready`  out  `N_REQ`  one-hot grant; combinational this cycle.
- `cdb_valid`  out  1  registered broadcast valid.
- `cdb_rob_idx`  out  `ROB_IDX_WIDTH`  registered tag.
- `cdb_rd_addr`  out  5  registered destination register.
- `cdb_data`  out  32  registered result.

## Operation
- Handshake: a transfer occurs when `req_valid[i] && req_ready[i]`.
  - Once a requester asserts `req_valid`, it holds valid and its payload stable until it is granted.
  - The arbiter never withdraws `req_ready` within a cycle based on its own outputs.
- Grant: at most one bit of `req_ready` is high per cycle, and only for a requester with `req_valid` = 1. If no requester is valid, `req_ready` = 0.
- Selection is round-robin from pointer `rr_ptr` (width ceil(log2 `N_REQ`)).
  - The winner is the first valid index at or after `rr_ptr`, scanning upward with wrap-around modulo `N_REQ`.
  - After a grant to index k, `rr_ptr` becomes (k+1) mod `N_REQ`.
  - With no grant, `rr_ptr` is unchanged.
- Broadcast: on a transfer, the winner's tag, rd_addr and data are registered into `cdb_*` and `cdb_valid` goes to 1 for exactly one cycle.
  - With no transfer, `cdb_valid` goes to 0 and the payload registers hold their previous values.
  - The CDB has no backpressure.
- `rd_addr` = 0 results are still broadcast so that the ROB marks them complete. Consumers ignore the register write.
- Flush:
  - While `flush` = 1, `req_ready` = 0 and no grant occurs.
  - `cdb_valid` is 0 in the cycle after `flush`, which also squashes any result that was registered in the flush cycle.
  - `rr_ptr` is preserved.
- Reset:
  - `cdb_valid` = 0, `cdb_rob_idx` = 0, `cdb_rd_addr` = 0, `cdb_data` = 0, `rr_ptr` = 0.
  - `req_ready` = 0 while `rst` = 1.
  - `rst` takes priority over `flush` and over any grant, including a transfer in progress.

## Timing
- Latency: a grant in cycle T appears on `cdb_*` in cycle T+1.
- Throughput: one result per cycle.
- Fairness:
  - Under continuous all-valid load, each requester is granted exactly once every `N_REQ` cycles.
  - Worst-case wait for a valid requester is `N_REQ`-1 cycles.
- Grant logic is combinational from `req_valid` and `rr_ptr` only, with no path from the `req_*` payload.
- Simultaneous `flush` and `req_valid`: the flush wins and the requester keeps `req_valid` (or drops it itself if flushed).

## Configuration
- `CDB_RR_EN`:
  - Defined: round-robin arbitration as above.
  - Undefined: fixed priority, lowest index wins. `rr_ptr` is not implemented and requester 0 always wins ties. All other behaviour, latency and flush/reset handling are identical.

## Test plan
- Reset: hold `rst` 2 cycles with all `req_valid` = 1 -> `req_ready` = 0 and `cdb_valid` = 0. First grant after release goes to index 0.
- Single requester: req 2 valid with rob_idx 7, rd 5, data 0xDEADBEEF -> `req_ready` = 0100 in cycle T. Next cycle `cdb_valid` = 1, `cdb_rob_idx` = 7, `cdb_rd_addr` = 5, `cdb_data` = 0xDEADBEEF. The cycle after that `cdb_valid` = 0.
- Round-robin wrap: all 4 valid continuously for 8 cycles -> grant order 0,1,2,3,0,1,2,3 and `cdb_valid` = 1 every cycle. With `CDB_RR_EN` undefined the order is 0 every cycle.
- Skip and wrap: `rr_ptr` = 3, only reqs 1 and 3 valid -> grant 3, then 1, then `rr_ptr` = 2.
- Flush: req 0 granted in cycle T and `flush` = 1 in cycle T+1 with req 1 valid -> `cdb_valid` = 1 in T+1 (from T), no grant in T+1, `cdb_valid` = 0 in T+2, and req 1 granted in T+2 if still valid.
- x0 destination: req 1 valid with rd_addr 0, rob_idx 12 -> broadcast with `cdb_valid` = 1, `cdb_rd_addr` = 0, `cdb_rob_idx` = 12.
